// File: rtl/systolic_feeder.sv
// Upstream feeder for the DIM x DIM output-stationary MAC array.
// Skews each accepted k-slice into diagonal edge streams, drives the
// array-wide enable, drains the pipeline and holds results until acked.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int K_WIDTH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [K_WIDTH-1:0]        k_len_i,
  input  logic                      vec_valid_i,
  output logic                      vec_ready_o,
  input  logic [DIM*DATA_WIDTH-1:0] vec_a_i,
  input  logic [DIM*DATA_WIDTH-1:0] vec_b_i,
  output logic [DIM*DATA_WIDTH-1:0] a_edge_o,
  output logic [DIM*DATA_WIDTH-1:0] b_edge_o,
  output logic                      start_operation_o,
  output logic                      busy_o,
  output logic                      result_valid_o,
  input  logic                      result_ack_i
);

  // Drain length: the last slice needs 2*DIM-1 edges to reach PE(DIM-1,DIM-1)
  localparam int DRAIN_CYCLES = 2 * DIM - 1;
  localparam int DCW          = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    RESULT
  } state_t;

  state_t             state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q;
  logic [K_WIDTH-1:0] k_cnt_q;
  logic [DCW-1:0]     drain_cnt_q;
  logic               accept;

  assign accept      = (state_q == LOAD) && vec_valid_i;
  assign vec_ready_o = (state_q == LOAD);

  // Next-state decode; LOAD ends on the K-th accepted slice, DRAIN after a fixed count
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (k_len_i == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (accept && (k_cnt_q == k_len_q - K_WIDTH'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (result_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status outputs (outputs track the next state)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q           <= IDLE;
      k_len_q           <= '0;
      k_cnt_q           <= '0;
      drain_cnt_q       <= '0;
      start_operation_o <= 1'b0;
      busy_o            <= 1'b0;
      result_valid_o    <= 1'b0;
    end else begin
      state_q           <= state_d;
      start_operation_o <= (state_d != IDLE);
      busy_o            <= (state_d != IDLE);
      result_valid_o    <= (state_d == RESULT);
      if ((state_q == IDLE) && start_i) begin
        k_len_q <= k_len_i;
      end
      if (state_q == IDLE) begin
        k_cnt_q <= '0;
      end else if (accept) begin
        k_cnt_q <= k_cnt_q + K_WIDTH'(1);
      end
      if (state_q != DRAIN) begin
        drain_cnt_q <= '0;
      end else begin
        drain_cnt_q <= drain_cnt_q + DCW'(1);
      end
    end
  end

  // Lane i owns an (i+1)-deep delay line; its last stage is the edge output
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_q [0:i];
    logic [DATA_WIDTH-1:0] b_q [0:i];
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;

    assign a_in = accept ? vec_a_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_in = accept ? vec_b_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Shift every cycle outside IDLE (zeros when nothing is accepted); IDLE clears the line
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end
      end else if (state_q == IDLE) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end
      end else begin
        a_q[0] <= a_in;
        b_q[0] <= b_in;
        for (int s = 1; s <= i; s++) begin
          a_q[s] <= a_q[s-1];
          b_q[s] <= b_q[s-1];
        end
      end
    end

    assign a_edge_o[i*DATA_WIDTH +: DATA_WIDTH] = a_q[i];
    assign b_edge_o[i*DATA_WIDTH +: DATA_WIDTH] = b_q[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder. Expected edge streams come from
// the skew rule (lane i shows the slice accepted i edges earlier), and the
// array result is rebuilt from the observed edges and compared with A*B.
module tb_systolic_feeder;

  localparam int DW     = 8;
  localparam int DIM    = 4;
  localparam int KW     = 8;
  localparam int KMAX   = 8;
  localparam int NDRAIN = 2 * DIM - 1;

  typedef logic [DIM*DW-1:0] lanes_t;

  typedef struct {
    int k;
    int gap_at;
    int gap_len;
    int poke;
    int pattern;
    int pe_i;
    int pe_j;
    int exp_pe;
    int exp_lat;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          vec_valid;
  logic          vec_ready;
  lanes_t        vec_a;
  lanes_t        vec_b;
  lanes_t        a_edge;
  lanes_t        b_edge;
  logic          start_op;
  logic          busy;
  logic          result_valid;
  logic          result_ack;

  int     Am [DIM][KMAX];
  int     Bm [KMAX][DIM];
  lanes_t accA [int];
  lanes_t accB [int];
  lanes_t histA [int];
  lanes_t histB [int];
  int     cyc    = 0;
  int     n_cmp  = 0;
  int     n_fail = 0;
  int     job_s;
  int     job_r;
  vec_t   tbl [5];

  systolic_feeder #(.DATA_WIDTH(DW), .DIM(DIM), .K_WIDTH(KW)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .start_i           (start),
    .k_len_i           (k_len),
    .vec_valid_i       (vec_valid),
    .vec_ready_o       (vec_ready),
    .vec_a_i           (vec_a),
    .vec_b_i           (vec_b),
    .a_edge_o          (a_edge),
    .b_edge_o          (b_edge),
    .start_operation_o (start_op),
    .busy_o            (busy),
    .result_valid_o    (result_valid),
    .result_ack_i      (result_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: cyc equals the number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got still running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int laneVal(input lanes_t v, input int l);
    logic signed [DW-1:0] x;
    x = v[l*DW +: DW];
    return int'(x);
  endfunction

  // Advance one cycle, sample at the falling edge and check both edge buses
  task automatic stepCycle();
    lanes_t ea, eb, t;
    @(posedge clk);
    @(negedge clk);
    ea = '0;
    eb = '0;
    for (int i = 0; i < DIM; i++) begin
      if (accA.exists(cyc - i)) begin t = accA[cyc - i]; ea[i*DW +: DW] = t[i*DW +: DW]; end
      if (accB.exists(cyc - i)) begin t = accB[cyc - i]; eb[i*DW +: DW] = t[i*DW +: DW]; end
    end
    histA[cyc] = a_edge;
    histB[cyc] = b_edge;
    checkOutput("a_edge", a_edge, ea);
    checkOutput("b_edge", b_edge, eb);
  endtask

  task automatic fillPattern(input int p, input int k);
    for (int kk = 0; kk < KMAX; kk++)
      for (int i = 0; i < DIM; i++) begin
        case (p)
          0: begin Am[i][kk] = (i == kk) ? 1 : 0; Bm[kk][i] = kk * DIM + i + 1; end
          1: begin Am[i][kk] = i + 1; Bm[kk][i] = i + 5; end
          2: begin Am[i][kk] = -128; Bm[kk][i] = -128; end
          default: begin
            Am[i][kk] = int'($urandom_range(0, 255)) - 128;
            Bm[kk][i] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    if (k > KMAX) $display("[TB] note: K above table size");
  endtask

  task automatic packSlice(input int kk);
    for (int i = 0; i < DIM; i++) begin
      vec_a[i*DW +: DW] = DW'(Am[i][kk]);
      vec_b[i*DW +: DW] = DW'(Bm[kk][i]);
    end
  endtask

  function automatic longint expProd(input int i, input int j, input int k);
    longint s = 0;
    for (int kk = 0; kk < k; kk++) s += longint'(Am[i][kk]) * longint'(Bm[kk][j]);
    return s;
  endfunction

  // PE(i,j) multiplies row-edge data delayed j cycles with column-edge data delayed i cycles
  function automatic longint peAccum(input int i, input int j, input int s, input int r);
    longint sum = 0;
    int a, b;
    for (int p = s; p < r; p++) begin
      a = histA.exists(p - j) ? laneVal(histA[p - j], i) : 0;
      b = histB.exists(p - i) ? laneVal(histB[p - i], j) : 0;
      sum += longint'(a) * longint'(b);
    end
    return sum;
  endfunction

  task automatic clearModel();
    accA.delete(); accB.delete(); histA.delete(); histB.delete();
  endtask

  // One full job: start, K slices (optional gap and stray starts), drain, result, ack
  task automatic applyStimulus(input int k, input int gap_at, input int gap_len,
                               input int poke, output int lat);
    clearModel();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_ready", vec_ready, 0);
    start = 1'b1;
    k_len = KW'(k);
    stepCycle();
    job_s = cyc;
    start = 1'b0;
    for (int kk = 0; kk < k; kk++) begin
      if (kk == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          vec_valid = 1'b0;
          start = poke[0];
          checkOutput("gap_ready", vec_ready, 1);
          stepCycle();
        end
      end
      start = poke[0];
      vec_valid = 1'b1;
      packSlice(kk);
      checkOutput("load_ready", vec_ready, 1);
      checkOutput("load_start_op", start_op, 1);
      checkOutput("load_busy", busy, 1);
      accA[cyc + 1] = vec_a;
      accB[cyc + 1] = vec_b;
      stepCycle();
    end
    vec_valid = 1'b0;
    start = 1'b0;
    vec_a = '0;
    vec_b = '0;
    for (int d = 0; d < NDRAIN; d++) begin
      checkOutput("drain_ready", vec_ready, 0);
      checkOutput("drain_result_valid", result_valid, 0);
      checkOutput("drain_busy", busy, 1);
      stepCycle();
    end
    job_r = cyc;
    lat = job_r - job_s;
    checkOutput("result_valid", result_valid, 1);
    checkOutput("result_start_op", start_op, 1);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        checkOutput($sformatf("pe_accum_%0d_%0d", i, j), peAccum(i, j, job_s, job_r), expProd(i, j, k));
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("result_hold_after_start", result_valid, 1);
    checkOutput("result_hold_busy", busy, 1);
    result_ack = 1'b1;
    stepCycle();
    result_ack = 1'b0;
    checkOutput("ack_result_valid", result_valid, 0);
    checkOutput("ack_start_op", start_op, 0);
    checkOutput("ack_busy", busy, 0);
    checkOutput("ack_ready", vec_ready, 0);
  endtask

  initial begin
    int lat;
    int k, gap_at, gap_len, exp_lat;
    tbl[0] = '{4, 99, 0, 0, 0, 2, 1, 10, 11};
    tbl[1] = '{1, 99, 0, 0, 1, 3, 3, 32, 8};
    tbl[2] = '{4, 2, 3, 1, 0, 2, 1, 10, 14};
    tbl[3] = '{4, 99, 0, 0, 2, 0, 0, 65536, 11};
    tbl[4] = '{0, 99, 0, 0, 0, 1, 2, 0, 7};

    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    vec_valid = 1'b0;
    vec_a = '0;
    vec_b = '0;
    result_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", vec_ready, 0);
    checkOutput("rst_start_op", start_op, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result_valid", result_valid, 0);
    checkOutput("rst_a_edge", a_edge, 0);
    checkOutput("rst_b_edge", b_edge, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int e = 0; e < 5; e++) begin
      fillPattern(tbl[e].pattern, tbl[e].k);
      applyStimulus(tbl[e].k, tbl[e].gap_at, tbl[e].gap_len, tbl[e].poke, lat);
      checkOutput($sformatf("latency_row%0d", e), lat, tbl[e].exp_lat);
      checkOutput($sformatf("pe_sample_row%0d", e),
                  peAccum(tbl[e].pe_i, tbl[e].pe_j, job_s, job_r), tbl[e].exp_pe);
    end

    // Reset in the third DRAIN cycle, then a fresh K=2 job
    clearModel();
    fillPattern(0, 4);
    start = 1'b1;
    k_len = KW'(4);
    stepCycle();
    start = 1'b0;
    for (int kk = 0; kk < 4; kk++) begin
      vec_valid = 1'b1;
      packSlice(kk);
      accA[cyc + 1] = vec_a;
      accB[cyc + 1] = vec_b;
      stepCycle();
    end
    vec_valid = 1'b0;
    stepCycle();
    stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", vec_ready, 0);
    checkOutput("midrst_start_op", start_op, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_result_valid", result_valid, 0);
    checkOutput("midrst_a_edge", a_edge, 0);
    checkOutput("midrst_b_edge", b_edge, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postrst_busy", busy, 0);
    fillPattern(3, 2);
    applyStimulus(2, 99, 0, 0, lat);
    checkOutput("postrst_latency", lat, 9);

    // Randomized jobs against the matrix-product and skew-rule model
    for (int r = 0; r < 6; r++) begin
      k = int'($urandom_range(1, 6));
      gap_at = int'($urandom_range(0, k));
      gap_len = int'($urandom_range(0, 3));
      exp_lat = k + ((gap_at < k) ? gap_len : 0) + NDRAIN;
      fillPattern(3, k);
      applyStimulus(k, gap_at, gap_len, int'($urandom_range(0, 1)), lat);
      checkOutput($sformatf("rand_latency_%0d", r), lat, exp_lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the DIM x DIM weight-stationary-free (output-stationary) MAC array built from pe instances.
- Accepts one k-slice per transfer: column k of A and row k of B. Delays each slice into diagonally skewed edge streams so A(i,k) and B(k,j) meet at PE(i,j).
- Drives the array-wide start_operation, drains the pipeline, then holds results stable until the consumer acknowledges.

Parameters:
- DATA_WIDTH, 8, width of one matrix element (signed).
- DIM, 4, array dimension; number of lanes on each edge.
- K_WIDTH, 8, width of the k_len_i field (max K = 2^K_WIDTH-1).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; sampled in IDLE only.
- k_len_i  in  K_WIDTH  inner dimension K; sampled with start_i.
- vec_valid_i  in  1  slice valid.
- vec_ready_o  out  1  slice ready.
- vec_a_i  in  DIM*DATA_WIDTH  lane i (bits [i*DATA_WIDTH +: DATA_WIDTH]) = A(i,k).
- vec_b_i  in  DIM*DATA_WIDTH  lane j = B(k,j).
- a_edge_o  out  DIM*DATA_WIDTH  row-edge inputs; lane i drives data_A_i of PE(i,0).
- b_edge_o  out  DIM*DATA_WIDTH  column-edge inputs; lane j drives data_B_i of PE(0,j).
- start_operation_o  out  1  array enable; drives start_operation_i of every PE.
- busy_o  out  1  high in every state except IDLE.
- result_valid_o  out  1  PE accum outputs are final.
- result_ack_i  in  1  consumer has read the results.

Behaviour:
- Clock and reset: clk_i is the clock. rst_n_i is an asynchronous, active-low reset.
- Reset values: state IDLE; all delay registers 0; a_edge_o and b_edge_o 0; vec_ready_o, start_operation_o, busy_o and result_valid_o all 0; K register and counters 0.
- All outputs are registered, except vec_ready_o, which is decoded from state.
- State IDLE:
  - start_i=1 latches k_len_i and moves to LOAD.
  - If k_len_i=0, moves directly to DRAIN instead.
  - start_i is ignored in every other state.
- State LOAD:
  - vec_ready_o=1.
  - Each cycle with vec_valid_i=1 is one transfer: the slice enters the delay lines and the k counter increments.
  - A cycle with vec_valid_i=0 inserts an all-zero slice. This is legal, because the uniform shift preserves A/B alignment and 0*x adds nothing.
  - After the K-th transfer: move to DRAIN and vec_ready_o=0 from the next cycle.
- Skew:
  - Lane i of A and lane j of B are delayed by i+1 and j+1 clock edges respectively, measured from the accepting edge.
  - The delay lines shift every cycle in LOAD and DRAIN, and shift zeros when nothing is accepted.
- State DRAIN:
  - Lasts exactly 2*DIM-1 cycles after the last accepting edge, or after the IDLE->DRAIN edge when K=0.
  - Zeros are shifted in throughout.
  - The final MAC of PE(DIM-1,DIM-1) completes on the last DRAIN edge; the state then moves to RESULT.
- State RESULT:
  - result_valid_o=1.
  - Edges are all zero, so every PE accum_o equals its accumulated sum.
  - result_ack_i=1 moves to IDLE.
- start_operation_o:
  - 1 in LOAD, DRAIN and RESULT; 0 in IDLE.
  - Going low on RESULT->IDLE clears all PE accumulators and overflow flags. Results must be read before acking.
- IDLE entry clears all delay registers.
- Reset mid-operation: immediate return to reset values. The PEs clear on the same reset.
- Arithmetic: no arithmetic in this block; data is passed bit-exact.

Test Plan:
1. DIM=4, K=4, A=identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, valid every cycle -> result_valid_o rises 7 cycles after the 4th accept edge; PE(i,j) accum = B(i,j), e.g. PE(2,1)=10; vec_ready_o low during DRAIN.
2. K=1, vec_a={4,3,2,1}, vec_b={8,7,6,5} (lane3..lane0) -> a_edge lane i = A(i,0) exactly during the cycle after edge accept+i+1, zero at all other times; b_edge identical; PE(i,j) accum = A(i,0)*B(0,j), e.g. PE(3,3)=32.
3. Repeat scenario 1 with vec_valid_i low for 3 cycles between slices 2 and 3 -> same results; result_valid_o delayed by exactly 3 cycles.
4. All A = -128, all B = -128, K=4 -> every PE accum = 65536, overflow flags 0; then result_ack_i -> start_operation_o low next cycle, accums read 0.
5. Assert rst_n_i low in the 3rd DRAIN cycle -> all outputs 0 immediately; after release, state IDLE, and a new start with K=2 produces correct results.
6. start_i pulsed during LOAD and RESULT -> ignored, no state change; start_i with k_len_i=0 -> DRAIN of 7 cycles, then result_valid_o=1 with all accums 0.
